// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue between IF and ID.
// The optional same-cycle bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam int          FQ_DEPTH     = 4;
    localparam int          FQ_PC_W      = 64;

endpackage

// File: rtl/fetch_queue_ram.sv
// fq_ram: DEPTH x W register array with one synchronous write port and one
// asynchronous read port; contents have no reset.
module fq_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 97,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, ir, pr_taken} with NOP on empty
// and synchronous flush. Define FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PC_W  = FQ_PC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_ir,
    input  logic                       in_pr_taken,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_ir,
    output logic                       out_pr_taken,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = PC_W + 33;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & flush_n;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction that decode takes this cycle never enters storage.
    assign w_push = in_valid & ~w_full & ~(w_bypass & out_ready);
    assign w_pop  = ~w_empty & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!flush_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fq_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push & flush_n),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_pc, in_ir, in_pr_taken}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        out_valid    = 1'b0;
        out_pc       = '0;
        out_ir       = NOP_INSN;
        out_pr_taken = 1'b0;
        if (!w_empty) begin
            out_valid    = 1'b1;
            out_pc       = w_rdata[ENT_W-1 -: PC_W];
            out_ir       = w_rdata[32:1];
            out_pr_taken = w_rdata[0];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!flush_n) begin
            out_valid    = 1'b0;
            out_pc       = '0;
            out_ir       = NOP_INSN;
            out_pr_taken = 1'b0;
        end else if (w_bypass) begin
            out_valid    = 1'b1;
            out_pc       = in_pc;
            out_ir       = in_ir;
            out_pr_taken = in_pr_taken;
        end
`endif
    end

    assign in_ready = ~w_full;
    assign count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, PC_W=64) with a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_n;
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_ir;
    logic            in_pr_taken;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_ir;
    logic            out_pr_taken;
    logic [2:0]      count;

    int total = 0;
    int bad   = 0;
    logic [PC_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_n      (flush_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_ir        (in_ir),
        .in_pr_taken  (in_pr_taken),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_ir       (out_ir),
        .out_pr_taken (out_pr_taken),
        .count        (count)
    );

    function automatic logic [31:0] mk_ir(input logic [PC_W-1:0] pc);
        return {pc[19:0], 12'h093};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
        in_valid    = v;
        in_pc       = pc;
        in_ir       = mk_ir(pc);
        in_pr_taken = pc[2];
        out_ready   = rdy;
        flush_n     = fl;
    endtask

    // Compare outputs to the model, advance the model, then cross one rising edge.
    task automatic tick(input string tag);
        logic            e_v;
        logic [PC_W-1:0] e_pc;
        logic            byp;
        #1;
        e_v  = (exp_q.size() != 0);
        e_pc = e_v ? exp_q[0] : '0;
        byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!flush_n) begin
            e_v = 1'b0; e_pc = '0;
        end else if (exp_q.size() == 0 && in_valid) begin
            e_v = 1'b1; e_pc = in_pc; byp = 1'b1;
        end
`endif
        chk($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(e_v));
        chk($sformatf("%s.out_pc", tag), out_pc, e_pc);
        chk($sformatf("%s.out_ir", tag), 64'(out_ir), 64'(e_v ? mk_ir(e_pc) : NOP));
        chk($sformatf("%s.out_pr_taken", tag), 64'(out_pr_taken), 64'(e_v ? e_pc[2] : 1'b0));
        chk($sformatf("%s.count", tag), 64'(count), 64'(exp_q.size()));
        chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'(exp_q.size() != DEPTH));
        if (!flush_n) begin
            exp_q.delete();
        end else if (!(byp && out_ready)) begin
            logic push_ok;
            push_ok = in_valid && (exp_q.size() != DEPTH);
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back(in_pc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        #1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_ir", 64'(out_ir), 64'(NOP));
        chk("rst.out_pc", out_pc, 64'd0);
        chk("rst.out_pr_taken", 64'(out_pr_taken), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency on an empty queue, decode ready.
        drive(1'b1, 64'h2000, 1'b1, 1'b1);
        tick("lat0");
`ifndef FETCH_QUEUE_BYPASS_EN
        chk("lat.count", 64'(count), 64'd1);
        chk("lat.out_ir", 64'(out_ir), 64'(32'h0200_0093));
`endif
        drive(1'b0, '0, 1'b1, 1'b1);
        tick("lat1");
        chk("lat.drained", 64'(count), 64'd0);

        // Fill with decode stalled; fifth push refused.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 1'b1);
            tick($sformatf("fill%0d", i));
        end
        chk("full.count", 64'(count), 64'd4);
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.head", out_pc, 64'h1000);

        drive(1'b0, '0, 1'b1, 1'b1);
        tick("pop0");
        chk("pop0.in_ready", 64'(in_ready), 64'd1);
        chk("pop0.head", out_pc, 64'h1004);
        for (int i = 1; i < 4; i++) tick($sformatf("pop%0d", i));
        chk("popped.count", 64'(count), 64'd0);
        drive(1'b1, 64'h1010, 1'b0, 1'b1);
        tick("repush");
        chk("repush.head", out_pc, 64'h1010);
        drive(1'b0, '0, 1'b1, 1'b1);
        tick("repush.pop");

        // Preload two, then push+pop every cycle across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h3000 + 64'(4 * i), 1'b0, 1'b1);
            tick($sformatf("pre%0d", i));
        end
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 64'h3000 + 64'(4 * i), 1'b1, 1'b1);
            tick($sformatf("stream%0d", i));
            chk($sformatf("stream%0d.count_const", i), 64'(count), 64'd2);
        end
        chk("stream.head", out_pc, 64'h3028);
        drive(1'b0, '0, 1'b1, 1'b1);
        tick("drain0");
        tick("drain1");

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h4000 + 64'(4 * i), 1'b0, 1'b1);
            tick($sformatf("hold%0d", i));
        end
        drive(1'b1, 64'h4100, 1'b1, 1'b0);
        tick("flush");
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.out_ir", 64'(out_ir), 64'(NOP));
        drive(1'b1, 64'h5000, 1'b0, 1'b1);
        tick("postflush");
        chk("postflush.head", out_pc, 64'h5000);
        chk("postflush.count", 64'(count), 64'd1);
        drive(1'b1, 64'h5004, 1'b0, 1'b1);
        tick("hold_b0");
        drive(1'b1, 64'h5008, 1'b0, 1'b1);
        tick("hold_b1");

        // Asynchronous reset mid-cycle with three entries held.
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("midrst.pre", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.out_ir", 64'(out_ir), 64'(NOP));
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue between IF and ID, replacing the single fixed IF/PD pipeline register with a DEPTH-entry FIFO of {pc, ir, pr_taken}. It decouples L1i refill stalls from decode stalls, supplies a NOP to decode when empty, and is flushed on branch mispredict or JALR redirect. Optional same-cycle bypass removes the one-cycle fill latency when the queue is empty.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- PC_W, 64, program counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_n  in  1  synchronous active-low flush (mispredict / JALR redirect)
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  queue can accept; IF stalls when low
- in_pc  in  PC_W  fetch PC
- in_ir  in  32  fetched instruction
- in_pr_taken  in  1  BPU predicted-taken flag
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head (low = decode stall)
- out_pc  out  PC_W  head PC
- out_ir  out  32  head instruction, 32'h13 when not valid
- out_pr_taken  out  1  head prediction flag, 0 when not valid
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation

- Storage: DEPTH-entry circular buffer; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; count tracked separately.
- Push: in_valid && in_ready → write entry at wr_ptr, wr_ptr+1.
- Pop: out_valid && out_ready → rd_ptr+1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- in_ready = (count != DEPTH); no credit for a same-cycle pop while full.
- out_valid = (count != 0); out_* driven combinationally from entry rd_ptr.
- Empty: out_ir = 32'h13, out_pr_taken = 0, out_pc = 0.
- Flush (flush_n = 0 at edge): count, wr_ptr, rd_ptr ← 0; any push or pop that cycle is discarded; entry contents not cleared.
- While flush_n = 0, in_ready is still combinational from count (IF redirect is handled by pc).
- Reset: async; same state as flush. Outputs at reset: out_valid 0, out_ir 32'h13, out_pr_taken 0, out_pc 0, count 0, in_ready 1.

## Timing

- Without bypass: instruction pushed at edge N is visible on out_* after edge N; minimum latency 1 cycle.
- Throughput: 1 instruction/cycle sustained for any DEPTH ≥ 2.
- Full queue with out_ready = 0: in_ready = 0 until the first pop edge; in_ready rises the cycle after that pop.
- Flush asserted in the same cycle as push: queue empty after the edge, count = 0.

## Configuration

- FETCH_QUEUE_BYPASS_EN defined: when count = 0 and in_valid = 1 and flush_n = 1, out_valid = 1 and out_* = in_* combinationally; if out_ready = 1 the instruction is consumed and not written (pointers and count unchanged); if out_ready = 0 it is pushed normally. Latency 0 when empty. While flush_n = 0, out_valid forced 0.
- Not defined: no combinational in_* → out_* path; latency always ≥ 1.

## Structure

- config.v gains `NOP_INSN (32'h13) and `FQ_DEPTH default; hart instantiates with DEPTH = `FQ_DEPTH.
- Sub-module fq_ram: DEPTH×(PC_W+33) register array, one synchronous write port, one asynchronous read port; no reset on contents.
- Pointer/count/bypass logic stays in fetch_queue.

## Test plan

- Reset mid-stream with 3 entries held → immediately count = 0, out_valid = 0, out_ir = 32'h13, in_ready = 1.
- DEPTH = 4, push pc 0x1000..0x1010 (5 words) with out_ready = 0 → count = 4, in_ready = 0, fifth push refused; raise out_ready → pops in order 0x1000, 0x1004, 0x1008, 0x100C, then 0x1010 after re-push.
- Continuous push+pop for 10 cycles across pointer wrap → count constant, out order = in order, no drop or duplicate.
- 3 entries held, flush_n = 0 with in_valid = 1 → next cycle count = 0, out_ir = 32'h13; pushed instruction not present.
- Bypass build, empty, in_ir = 32'h00500093, out_ready = 1 → same cycle out_ir = 32'h00500093, count stays 0; non-bypass build → visible one cycle later, count = 1 for one cycle.
